// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive front end feeding the RX FIFO write port.
// Synchronizes rx_in, oversamples with a baud tick, recovers LSB-first frames
// using a 3-sample majority vote and strobes each good byte into the FIFO.
// Framing and overrun conditions are kept as sticky flags until clearErr_in.
// Optional macro UART_RX_PARITY_EN adds a parity bit (PARITY_ODD selects odd)
// and a sticky parityErr_flag; undefined builds are plain 8N1.
module uart_rx_deserializer #(
  parameter int BAUD_DIV       = 27,
  parameter int OVERSAMPLE_POW = 4,
  parameter int DATA_BITS      = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD     = 0
`endif
) (
  input  logic                 writeClk_in,
  input  logic                 rstN,
  input  logic                 rx_in,
  input  logic                 inReady_in,
  input  logic                 clearErr_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 writeEn_out,
  output logic                 busy_out,
  output logic                 framingErr_flag,
`ifdef UART_RX_PARITY_EN
  output logic                 parityErr_flag,
`endif
  output logic                 overrun_flag
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int OS_W  = OVERSAMPLE_POW;

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [OS_W-1:0]  SAMP_EARLY = OS_W'((1 << (OS_W - 1)) - 1);
  localparam logic [OS_W-1:0]  SAMP_MID   = OS_W'(1 << (OS_W - 1));
  localparam logic [OS_W-1:0]  SAMP_LATE  = OS_W'((1 << (OS_W - 1)) + 1);
  localparam logic [OS_W-1:0]  SAMP_LAST  = {OS_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY     = 3'd4;
  localparam logic [2:0] AFTER_DATA = PARITY;
  localparam logic       PAR_ODD    = (PARITY_ODD != 0);
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic                 r_rxMeta;
  logic                 r_rxSync;
  logic [CNT_W-1:0]     r_baudCnt;
  logic [OS_W-1:0]      r_sampCnt;
  logic [2:0]           r_state;
  logic                 r_armed;
  logic                 r_smpEarly;
  logic                 r_smpMid;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_wrEn;
  logic                 r_framingErr;
  logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_parBit;
  logic                 r_parityErr;
`endif

  logic w_tick;
  logic w_startGo;
  logic w_atEarly;
  logic w_atMid;
  logic w_atLate;
  logic w_atLast;
  logic w_maj;
  logic w_parOk;
  logic w_stopDecide;
  logic w_writeGo;
  logic w_setFraming;
  logic w_setOverrun;

  assign w_tick    = (r_baudCnt == BAUD_LAST);
  // Start is accepted only after the line has been seen idle-high (break guard)
  assign w_startGo = (r_state == IDLE) && r_armed && !r_rxSync;
  assign w_atEarly = w_tick && (r_sampCnt == SAMP_EARLY);
  assign w_atMid   = w_tick && (r_sampCnt == SAMP_MID);
  assign w_atLate  = w_tick && (r_sampCnt == SAMP_LATE);
  assign w_atLast  = w_tick && (r_sampCnt == SAMP_LAST);
  // Third vote is the live synchronized sample at the decision tick
  assign w_maj     = (r_smpEarly & r_smpMid) | (r_smpEarly & r_rxSync) | (r_smpMid & r_rxSync);

`ifdef UART_RX_PARITY_EN
  assign w_parOk   = ((^r_shift) ^ r_parBit) == PAR_ODD;
`else
  assign w_parOk   = 1'b1;
`endif

  assign w_stopDecide = (r_state == STOP) && w_atLate;
  assign w_writeGo    = w_stopDecide && w_maj && w_parOk && inReady_in;
  assign w_setFraming = w_stopDecide && !w_maj;
  assign w_setOverrun = w_stopDecide && w_maj && w_parOk && !inReady_in;

  assign data_out        = r_data;
  assign writeEn_out     = r_wrEn;
  assign busy_out        = (r_state != IDLE);
  assign framingErr_flag = r_framingErr;
  assign overrun_flag    = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parityErr_flag  = r_parityErr;
`endif

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge writeClk_in) begin
    if (!rstN) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx_in;
      r_rxSync <= r_rxMeta;
    end
  end

  // Oversample tick divider, re-phased on every accepted start edge
  always_ff @(posedge writeClk_in) begin
    if (!rstN || w_startGo || w_tick) begin
      r_baudCnt <= '0;
    end else begin
      r_baudCnt <= r_baudCnt + 1'b1;
    end
  end

  // Per-bit sample position and the two early majority samples
  always_ff @(posedge writeClk_in) begin
    if (!rstN) begin
      r_sampCnt  <= '0;
      r_smpEarly <= 1'b1;
      r_smpMid   <= 1'b1;
    end else begin
      if (r_state == IDLE) begin
        r_sampCnt <= '0;
      end else if (w_tick) begin
        r_sampCnt <= r_sampCnt + 1'b1;
      end
      if (w_atEarly) r_smpEarly <= r_rxSync;
      if (w_atMid)   r_smpMid   <= r_rxSync;
    end
  end

  // Frame sequencing, bit assembly and the one-cycle FIFO write strobe
  always_ff @(posedge writeClk_in) begin
    if (!rstN) begin
      r_state  <= IDLE;
      r_armed  <= 1'b0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_wrEn   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parBit <= 1'b0;
`endif
    end else begin
      r_wrEn <= w_writeGo;
      if (w_writeGo) r_data <= r_shift;
      case (r_state)
        IDLE: begin
          if (r_rxSync) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= START;
            r_armed <= 1'b0;
          end
        end
        START: begin
          if (w_atLate && w_maj) begin
            r_state <= IDLE;
          end else if (w_atLast) begin
            r_state  <= DATA;
            r_bitIdx <= '0;
          end
        end
        DATA: begin
          if (w_atLate) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_atLast) begin
            if (r_bitIdx == IDX_LAST) begin
              r_state <= AFTER_DATA;
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_atLate) r_parBit <= w_maj;
          if (w_atLast) r_state <= STOP;
        end
`endif
        STOP: begin
          // Leave half a bit early so a back-to-back start edge is not missed
          if (w_atLate) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge writeClk_in) begin
    if (!rstN) begin
      r_framingErr <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr  <= 1'b0;
`endif
    end else begin
      if (w_setFraming)     r_framingErr <= 1'b1;
      else if (clearErr_in) r_framingErr <= 1'b0;
      if (w_setOverrun)     r_overrun <= 1'b1;
      else if (clearErr_in) r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (w_stopDecide && w_maj && !w_parOk) r_parityErr <= 1'b1;
      else if (clearErr_in)                  r_parityErr <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive front end that sits directly upstream of the UART controller's receive FIFO, in the FIFO write-clock domain (writeClk_in).
- Synchronizes and oversamples the serial RX line, recovers 8N1 frames LSB-first, and pushes each good byte into the FIFO.
- The FIFO input-ready flag is the only back-pressure. Framing and overrun errors are reported as sticky flags.

Parameters:
- BAUD_DIV, 27, writeClk_in cycles per oversample tick (clk / (baud*16)); legal range ≥2.
- OVERSAMPLE_POW, 4, oversample ratio as a power of 2 (16 samples per bit).
- DATA_BITS, 8, data bits per frame; equals FIFO word width.

Ports:
- writeClk_in  input  1  free-running clock, shared with the FIFO write side.
- rstN  input  1  synchronous, active-low reset.
- rx_in  input  1  asynchronous serial line, idle high.
- inReady_in  input  1  FIFO input-ready flag (high = not full).
- clearErr_in  input  1  one-cycle pulse that clears both sticky error flags.
- data_out  output  DATA_BITS  received byte; drives the FIFO data input.
- writeEn_out  output  1  one-cycle write strobe; drives both FIFO write enables.
- busy_out  output  1  high while a frame is in progress.
- framingErr_flag  output  1  sticky: stop bit sampled low.
- overrun_flag  output  1  sticky: byte completed while the FIFO was full.

Behaviour:
- Reset (rstN low at a writeClk_in edge): FSM→IDLE, all counters cleared, sync flops set to 1.
  - data_out=0, writeEn_out=0, busy_out=0, framingErr_flag=0, overrun_flag=0.
  - Reset mid-frame abandons the frame; no write is issued.
- Synchronizer: rx_in passes through 2 flops (rxSync) before any use. Metastability latency is 2 cycles.
- Tick generator:
  - Counter runs 0..BAUD_DIV-1, width $clog2(BAUD_DIV); tick is asserted for 1 cycle at BAUD_DIV-1, then the counter wraps to 0.
  - Counter is cleared on entry to START so the frame is phase-aligned.
- Sample counter: 0..15 per bit, advances on tick.
  - Samples are captured at counts 7, 8 and 9; the bit value is the 2-of-3 majority, decided at count 9.
  - Bit period ends at tick count 15.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: rxSync==0 → START. busy_out=0 only in IDLE.
  - START: majority at count 9 == 1 → IDLE (false start, no flags). At end of count 15 → DATA with bit index 0.
  - DATA: majority shifted into the shift register LSB-first at count 9. At end of count 15, the bit index increments; after bit DATA_BITS-1 → STOP.
  - STOP: the decision at count 9 returns the FSM to IDLE immediately (half-bit early, to allow back-to-back frames).
- STOP decision outcomes:
  - Stop==1 and inReady_in==1: data_out←shift register; writeEn_out=1 on the next cycle for exactly 1 cycle.
  - Stop==1 and inReady_in==0: no write, data_out unchanged, overrun_flag←1.
  - Stop==0: no write, data_out unchanged, framingErr_flag←1. Overrun is not evaluated.
- data_out holds its value until the next successful write.
- Back-to-back frames: writeEn_out is never asserted on consecutive cycles. The minimum spacing is one frame time.
- Error flags: clearErr_in clears both. If a set and a clear land in the same cycle, the set wins.
- Line held low (break): the frame fails on its stop bit (framing error). IDLE is not re-armed for a new start until rxSync has been seen high.

Optional Feature:
- UART_RX_PARITY_EN
- Defined:
  - A PARITY state is added between DATA and STOP; it samples one bit using the same 7/8/9 majority.
  - Parameter PARITY_ODD (default 0 = even) selects the check.
  - A mismatch sets an extra sticky output parityErr_flag (reset 0, cleared by clearErr_in) and suppresses the write.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state, no parityErr_flag port, 8N1 only.

Test Plan:
- BAUD_DIV=4 (64 clk/bit). Send 0xA5 8N1 with inReady_in=1 → exactly one writeEn_out pulse, data_out=0xA5, both flags 0, busy_out low after the stop-bit mid-point.
- Send 0x00 then 0xFF back-to-back with no idle gap → two pulses ~640 clks apart, data 0x00 then 0xFF, no errors.
- 0x3C frame with the stop bit driven low → no writeEn_out, framingErr_flag=1, data_out unchanged. Then pulse clearErr_in → flag 0.
- inReady_in=0 while 0x5A completes → no write, overrun_flag=1. Pulse clearErr_in in the same cycle as a second overrun → flag stays 1.
- 20-clk low glitch on idle rx_in → return to IDLE, no write, no flags. A 1-clk glitch inside data bit 3 of 0x08 is rejected by the majority vote → 0x08 written.
- rstN low at data bit 4 of a frame → all outputs 0 at the next edge. The next full frame 0x81 is received correctly.
